// File: rtl/cam_pattern_tx_if.sv
// Camera parallel bus carrying vsync/href framing and byte-serial RGB565 pixel data.
interface cam_pattern_tx_if;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output vsync, output href, output data);
    modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/cam_pattern_tx.sv
// OV7670-style test-pattern transmitter: vsync/href frame timing with byte-serial RGB565 pixels.
module cam_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [15:0]      i_solid,
    cam_pattern_tx_if.master o_cam,
    output logic             o_sof,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt
);
    localparam int LINE_CYC  = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_CYC  = 2 * H_ACTIVE;
    localparam int TOT_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int BW        = $clog2(LINE_CYC);
    localparam int LW        = $clog2(TOT_LINES + 1);

    localparam logic [31:0] COL1 = 32'(H_ACTIVE / 3);
    localparam logic [31:0] COL2 = 32'(2 * (H_ACTIVE / 3));
    localparam logic [31:0] ROW1 = 32'(V_ACTIVE / 3);
    localparam logic [31:0] ROW2 = 32'(2 * (V_ACTIVE / 3));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] b);
        case (b)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] grid_color(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: grid_color = 16'hF800;
            4'b00_01: grid_color = 16'hFD20;
            4'b00_10: grid_color = 16'hFFE0;
            4'b01_00: grid_color = 16'h07E0;
            4'b01_01: grid_color = 16'h001F;
            4'b01_10: grid_color = 16'hFFFF;
            4'b10_00: grid_color = 16'hF800;
            4'b10_01: grid_color = 16'h07E0;
            4'b10_10: grid_color = 16'h001F;
            default:  grid_color = 16'h0000;
        endcase
    endfunction

    state_t          r_state;
    logic [BW-1:0]   r_byte;
    logic [LW-1:0]   r_line;
    logic [15:0]     r_ramp;
    logic [1:0]      r_mode;
    logic [15:0]     r_solid;
    logic            r_vsync;
    logic            r_href;
    logic [7:0]      r_data;
    logic            r_sof;
    logic            r_busy;
    logic [15:0]     r_frame_cnt;

    state_t          w_state_nxt;
    logic [BW-1:0]   w_byte_nxt;
    logic [LW-1:0]   w_line_nxt;
    logic [LW-1:0]   w_line_max;
    logic            w_start;
    logic            w_frame_done;
    logic            w_pix_done;
    logic [15:0]     w_ramp_nxt;
    logic [31:0]     w_x32;
    logic [31:0]     w_y32;
    logic [2:0]      w_bar;
    logic [1:0]      w_col;
    logic [1:0]      w_row;
    logic [15:0]     w_pix;
    logic            w_href_nxt;
    logic [7:0]      w_data_nxt;

    // Frame sequencing: advance byte/line counters and walk the phases of a frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_nxt   = r_byte;
        w_line_nxt   = r_line;
        w_start      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_VSYNC:  w_line_max = LW'(VSYNC_LINES - 1);
            S_VBACK:  w_line_max = LW'(V_BACK - 1);
            S_ACTIVE: w_line_max = LW'(V_ACTIVE - 1);
            S_VFRONT: w_line_max = LW'(V_FRONT - 1);
            default:  w_line_max = '0;
        endcase
        case (r_state)
            S_IDLE: begin
                w_byte_nxt = '0;
                w_line_nxt = '0;
                if (i_enable) begin
                    w_state_nxt = S_VSYNC;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT: begin
                if (r_byte != BW'(LINE_CYC - 1)) begin
                    w_byte_nxt = r_byte + BW'(1);
                end else if (r_line != w_line_max) begin
                    w_byte_nxt = '0;
                    w_line_nxt = r_line + LW'(1);
                end else begin
                    w_byte_nxt = '0;
                    w_line_nxt = '0;
                    case (r_state)
                        S_VSYNC:  w_state_nxt = S_VBACK;
                        S_VBACK:  w_state_nxt = S_ACTIVE;
                        S_ACTIVE: w_state_nxt = S_VFRONT;
                        default: begin
                            // End of VFRONT: the only place besides IDLE where i_enable is honoured.
                            w_frame_done = 1'b1;
                            if (i_enable) begin
                                w_state_nxt = S_VSYNC;
                                w_start     = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = '0;
                w_line_nxt  = '0;
            end
        endcase
    end

    // Pixel generation for the upcoming cycle, so every output can be registered directly.
    always_comb begin
        w_pix_done = (r_state == S_ACTIVE) && (r_byte < BW'(HREF_CYC)) && r_byte[0];
        if (w_start) begin
            w_ramp_nxt = 16'd0;
        end else if (w_pix_done) begin
            w_ramp_nxt = r_ramp + 16'd1;
        end else begin
            w_ramp_nxt = r_ramp;
        end
        w_x32 = 32'(w_byte_nxt[BW-1:1]);
        w_y32 = 32'(w_line_nxt);
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({w_x32[28:0], 3'b000} >= 32'(k * H_ACTIVE)) begin
                w_bar = w_bar + 3'd1;
            end else begin
                w_bar = w_bar;
            end
        end
        if (w_x32 >= COL2) begin
            w_col = 2'd2;
        end else if (w_x32 >= COL1) begin
            w_col = 2'd1;
        end else begin
            w_col = 2'd0;
        end
        if (w_y32 >= ROW2) begin
            w_row = 2'd2;
        end else if (w_y32 >= ROW1) begin
            w_row = 2'd1;
        end else begin
            w_row = 2'd0;
        end
        case (r_mode)
            2'd0:    w_pix = r_solid;
            2'd1:    w_pix = bar_color(w_bar);
            2'd2:    w_pix = grid_color(w_row, w_col);
            default: w_pix = w_ramp_nxt;
        endcase
        w_href_nxt = (w_state_nxt == S_ACTIVE) && (w_byte_nxt < BW'(HREF_CYC));
        if (w_href_nxt) begin
            w_data_nxt = w_byte_nxt[0] ? w_pix[7:0] : w_pix[15:8];
        end else begin
            w_data_nxt = 8'h00;
        end
    end

    // State, counters, latched frame settings and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_byte      <= '0;
            r_line      <= '0;
            r_ramp      <= 16'd0;
            r_mode      <= 2'd0;
            r_solid     <= 16'd0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= 8'h00;
            r_sof       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_line  <= w_line_nxt;
            r_ramp  <= w_ramp_nxt;
            if (w_start) begin
                r_mode  <= i_mode;
                r_solid <= i_solid;
            end else begin
                r_mode  <= r_mode;
                r_solid <= r_solid;
            end
            r_vsync     <= (w_state_nxt == S_VSYNC);
            r_href      <= w_href_nxt;
            r_data      <= w_data_nxt;
            r_sof       <= w_start;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_cnt <= w_frame_done ? (r_frame_cnt + 16'd1) : r_frame_cnt;
        end
    end

    assign o_cam.vsync = r_vsync;
    assign o_cam.href  = r_href;
    assign o_cam.data  = r_data;
    assign o_sof       = r_sof;
    assign o_busy      = r_busy;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Scoreboard bench: a frame-position reference model queues expected outputs; a monitor compares each cycle.
module tb_cam_pattern_tx;
    localparam int HA    = 6;
    localparam int VA    = 3;
    localparam int HB    = 4;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LC    = 2 * HA + HB;
    localparam int FRAME = LC * (VS + VB + VA + VF);

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    localparam logic [15:0] GRID [9] = '{16'hF800, 16'hFD20, 16'hFFE0, 16'h07E0, 16'h001F,
                                         16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};

    typedef struct packed {
        logic        vsync;
        logic        href;
        logic        sof;
        logic        busy;
        logic [7:0]  data;
        logic [15:0] fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic [15:0] i_solid;
    logic        o_sof;
    logic        o_busy;
    logic [15:0] o_frame_cnt;

    cam_pattern_tx_if cam ();

    cam_pattern_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_mode     (i_mode),
        .i_solid    (i_solid),
        .o_cam      (cam),
        .o_sof      (o_sof),
        .o_busy     (o_busy),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        exp_q [$];
    exp_t        cur;
    int          m_t     = -1;
    logic [15:0] m_cnt   = 16'd0;
    logic [1:0]  m_mode  = 2'd0;
    logic [15:0] m_solid = 16'd0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %h required %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [15:0] pattern(input logic [1:0] mode, input logic [15:0] solid,
                                            input int x, input int y);
        int c, r;
        c = (x < HA / 3) ? 0 : ((x < 2 * (HA / 3)) ? 1 : 2);
        r = (y < VA / 3) ? 0 : ((y < 2 * (VA / 3)) ? 1 : 2);
        case (mode)
            2'd0:    return solid;
            2'd1:    return BARS[(x * 8) / HA];
            2'd2:    return GRID[3 * r + c];
            default: return 16'(y * HA + x);
        endcase
    endfunction

    function automatic exp_t model_out(input int t, input logic [15:0] cnt,
                                       input logic [1:0] mode, input logic [15:0] solid);
        exp_t        e;
        int          line, b;
        logic [15:0] pix;
        e = '0;
        e.fcnt = cnt;
        if (t >= 0) begin
            line    = t / LC;
            b       = t % LC;
            e.busy  = 1'b1;
            e.sof   = (t == 0);
            e.vsync = (line < VS);
            if (line >= VS + VB && line < VS + VB + VA && b < 2 * HA) begin
                pix    = pattern(mode, solid, b / 2, line - (VS + VB));
                e.href = 1'b1;
                e.data = (b % 2 == 0) ? pix[15:8] : pix[7:0];
            end
        end
        return e;
    endfunction

    function automatic int next_t(input int t, input logic rst, input logic en);
        if (rst)                       return -1;
        if (t < 0 || t == FRAME - 1)   return en ? 0 : -1;
        return t + 1;
    endfunction

    function automatic logic [15:0] next_cnt(input int t, input logic rst, input logic [15:0] cnt);
        if (rst)            return 16'd0;
        if (t == FRAME - 1) return cnt + 16'd1;
        return cnt;
    endfunction

    // Reference model: sample the same inputs as the DUT and queue the expected next-cycle outputs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        exp_q.push_back(model_out(next_t(m_t, i_rst, i_enable), next_cnt(m_t, i_rst, m_cnt),
                                  (!i_rst && next_t(m_t, i_rst, i_enable) == 0) ? i_mode : m_mode,
                                  (!i_rst && next_t(m_t, i_rst, i_enable) == 0) ? i_solid : m_solid));
        if (!i_rst && next_t(m_t, i_rst, i_enable) == 0) begin
            m_mode  <= i_mode;
            m_solid <= i_solid;
        end
        m_cnt <= next_cnt(m_t, i_rst, m_cnt);
        m_t   <= next_t(m_t, i_rst, i_enable);
    end

    // Monitor: pop the expectation for the cycle on display and compare every output.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("vsync",     16'(cam.vsync), 16'(cur.vsync));
            chk("href",      16'(cam.href),  16'(cur.href));
            chk("data",      16'(cam.data),  16'(cur.data));
            chk("sof",       16'(o_sof),     16'(cur.sof));
            chk("busy",      16'(o_busy),    16'(cur.busy));
            chk("frame_cnt", o_frame_cnt,    cur.fcnt);
        end
    end

    task automatic wait_href(input int budget);
        int n;
        n = 0;
        while (cam.href !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_href", 16'(cam.href), 16'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 16'(o_busy), 16'd0);
    endtask

    // Stimulus: directed scenarios from the frame rules, then randomized enable/mode/reset traffic.
    initial begin
        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_mode   = 2'd0;
        i_solid  = 16'h0000;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);

        i_solid  = 16'hA55A;
        i_enable = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        i_mode = 2'd1;
        repeat (FRAME) @(negedge clk);
        i_mode = 2'd2;
        repeat (FRAME) @(negedge clk);
        i_mode = 2'd3;
        repeat (2 * FRAME) @(negedge clk);

        wait_href(2 * FRAME);
        i_enable = 1'b0;
        i_mode   = 2'd0;
        wait_idle(2 * FRAME);
        repeat (20) @(negedge clk);

        i_mode   = 2'd2;
        i_enable = 1'b1;
        wait_href(2 * FRAME);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        for (int s = 0; s < 40; s++) begin
            i_enable = ($urandom_range(0, 3) != 0);
            i_mode   = 2'($urandom_range(0, 3));
            i_solid  = 16'($urandom);
            i_rst    = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            i_rst = 1'b0;
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end

        i_enable = 1'b0;
        wait_idle(2 * FRAME);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
